// File: rtl/regfile_dump_loader.sv
// Register-file initiator: dumps a wrapping address range as an {addr, data} stream, or loads
// a word stream into consecutive registers. Define REGFILE_DUMP_CHECKSUM_EN for a running checksum.
module regfile_dump_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [ADDR_W-1:0] readReg,
    input  logic [DATA_W-1:0] readData,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outAddr,
    output logic [DATA_W-1:0] outData,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {StIdle, StRd, StSend, StLdWait, StWr, StFin} state_t;

    localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [ADDR_W:0]   cntQ, cntD;
    logic              outValidQ, outValidD;
    logic [ADDR_W-1:0] outAddrQ, outAddrD, writeRegQ, writeRegD;
    logic [DATA_W-1:0] outDataQ, outDataD, writeDataQ, writeDataD;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   rangeCnt;

    // Subtraction wraps mod 2^ADDR_W, so a reversed range walks through the top address to 0.
    assign span     = lastReg - firstReg;
    assign rangeCnt = {1'b0, span} + CntOne;

    always_comb begin
        stateD     = stateQ;
        addrD      = addrQ;
        cntD       = cntQ;
        outValidD  = outValidQ;
        outAddrD   = outAddrQ;
        outDataD   = outDataQ;
        writeRegD  = writeRegQ;
        writeDataD = writeDataQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    addrD  = firstReg;
                    cntD   = rangeCnt;
                    stateD = mode ? StLdWait : StRd;
                end
            end
            StRd: begin
                if (abort) begin
                    stateD = StFin;
                end else begin
                    outDataD  = readData;
                    outAddrD  = addrQ;
                    outValidD = 1'b1;
                    stateD    = StSend;
                end
            end
            StSend: begin
                if (outReady) begin
                    outValidD = 1'b0;
                    cntD      = cntQ - CntOne;
                    if (cntQ == CntOne || abort) begin
                        stateD = StFin;
                    end else begin
                        addrD  = addrQ + AddrOne;
                        stateD = StRd;
                    end
                end else if (abort) begin
                    outValidD = 1'b0;
                    stateD    = StFin;
                end
            end
            StLdWait: begin
                if (inValid) begin
                    writeDataD = inData;
                    writeRegD  = addrQ;
                end
                if (abort) begin
                    stateD = StFin;
                end else if (inValid) begin
                    stateD = StWr;
                end
            end
            StWr: begin
                // The write in this cycle always completes, even alongside abort.
                cntD = cntQ - CntOne;
                if (cntQ == CntOne || abort) begin
                    stateD = StFin;
                end else begin
                    addrD  = addrQ + AddrOne;
                    stateD = StLdWait;
                end
            end
            StFin:   stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ     <= StIdle;
            addrQ      <= '0;
            cntQ       <= '0;
            outValidQ  <= 1'b0;
            outAddrQ   <= '0;
            outDataQ   <= '0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
        end else begin
            stateQ     <= stateD;
            addrQ      <= addrD;
            cntQ       <= cntD;
            outValidQ  <= outValidD;
            outAddrQ   <= outAddrD;
            outDataQ   <= outDataD;
            writeRegQ  <= writeRegD;
            writeDataQ <= writeDataD;
        end
    end

    assign busy      = (stateQ != StIdle) && (stateQ != StFin);
    assign done      = (stateQ == StFin);
    assign regWrite  = (stateQ == StWr) && (writeRegQ != '0);
    assign inReady   = (stateQ == StLdWait);
    assign readReg   = addrQ;
    assign writeReg  = writeRegQ;
    assign writeData = writeDataQ;
    assign outValid  = outValidQ;
    assign outAddr   = outAddrQ;
    assign outData   = outDataQ;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksumQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            checksumQ <= '0;
        end else if (stateQ == StIdle && start) begin
            checksumQ <= '0;
        end else if (stateQ == StSend && outReady) begin
            checksumQ <= checksumQ + outDataQ;
        end else if (stateQ == StLdWait && inValid) begin
            checksumQ <= checksumQ + inData;
        end
    end

    assign checksum = checksumQ;
`endif

endmodule

// File: doc/regfile_dump_loader.md
Name: regfile_dump_loader

Overview:
- Initiator-side controller for the register file: drives its write port (regWrite/writeReg/writeData) and one read port (readReg/readData).
- Dump mode: walks an address range, reads each register and streams {address, data} out over a valid/ready interface.
- Load mode: accepts words from a valid/ready input stream and writes them to consecutive registers.
- Used by the bench and debug path to preload and inspect architectural state without the datapath.

Parameters:
- DATA_W, 32, register data width (writeData/readData/stream data).
- ADDR_W, 5, register address width (32 registers).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- mode  in  1  0 = dump, 1 = load; sampled with start.
- firstReg  in  ADDR_W  first register of range; sampled with start.
- lastReg  in  ADDR_W  last register of range (inclusive); sampled with start.
- abort  in  1  terminate the current operation.
- busy  out  1  high from the cycle after start until return to IDLE.
- done  out  1  one-cycle pulse at completion or abort.
- regWrite  out  1  register-file write enable.
- writeReg  out  ADDR_W  write address.
- writeData  out  DATA_W  write data.
- readReg  out  ADDR_W  read address.
- readData  in  DATA_W  read data; combinational from readReg in the same cycle.
- outValid  out  1  dump stream valid.
- outReady  in  1  dump stream ready.
- outAddr  out  ADDR_W  register address of outData.
- outData  out  DATA_W  dumped register value.
- inValid  in  1  load stream valid.
- inReady  out  1  load stream ready.
- inData  in  DATA_W  load word.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; busy, done, regWrite, outValid, inReady = 0; writeReg, writeData, readReg, outAddr, outData = 0; internal address and count = 0.
- Range and count:
  - count = ((lastReg - firstReg) mod 2^ADDR_W) + 1.
  - firstReg > lastReg wraps through 31 -> 0; e.g. 30..1 is 30, 31, 0, 1 (count 4).
  - firstReg == lastReg gives count 1.
  - Address increments mod 2^ADDR_W.
- States: IDLE, RD, SEND, LDWAIT, WR, FIN.
- IDLE:
  - start=1 latches mode, address = firstReg and count.
  - Next state is RD (mode 0) or LDWAIT (mode 1).
  - start while not in IDLE is ignored.
- RD:
  - readReg = address.
  - At the clock edge, outData <= readData and outAddr <= address; outValid goes 1; go to SEND.
- SEND:
  - outValid, outData and outAddr are held stable until outValid && outReady.
  - On handshake: outValid drops next cycle and count decrements.
  - If count was 1, go to FIN; otherwise address+1 and go to RD.
  - Throughput: one word per 2 cycles with outReady held high.
- LDWAIT:
  - inReady = 1 (combinational in this state only).
  - On inValid && inReady: writeData <= inData, writeReg <= address; go to WR.
- WR:
  - regWrite = 1 for exactly one cycle.
  - If writeReg == 0, regWrite stays 0: the word is consumed, register 0 is never written.
  - Then decrement count; go to FIN if count was 1, else address+1 and LDWAIT.
- FIN: done = 1 for one cycle; busy drops; then IDLE.
- abort:
  - In any non-IDLE state, go to FIN next cycle.
  - outValid drops and no further regWrite is issued.
  - An abort in the same cycle as a completing handshake or write completes that transfer first; done is still a single pulse.
- busy = 1 in every state except IDLE; it is 0 in the done cycle.
- RST mid-operation: immediate IDLE with no done pulse; a pending write is dropped.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W-1:0], reset 0, cleared on an accepted start.
  - Each dump handshake or load acceptance adds that word modulo 2^DATA_W.
  - Words for register 0 are included.
  - The value is stable from the done pulse until the next start.
- Not defined: no checksum port and no adder; all other behaviour is identical.

Test Plan:
- Load mode=1, firstReg=3, lastReg=5, inData 22, 7, 9 with inValid held high -> regWrite pulses with writeReg 3/4/5 and writeData 22/7/9; done pulses once; inReady is low afterwards.
- Dump 3..5 with readData modelled from that load, outReady=1 -> outAddr/outData sequence (3,22), (4,7), (5,9); one word every 2 cycles; done after the third handshake.
- Dump 30..1 with outReady stalled 3 cycles on the second word -> order 30, 31, 0, 1; outData/outAddr held stable during the stall; exactly 4 handshakes.
- Load 0..1 with words 5, 6 -> no regWrite for register 0; register 1 written with 6; both words consumed.
- Abort asserted in SEND of a 4-word dump, then RST asserted mid-load -> abort gives done next cycle with outValid 0; RST clears busy/regWrite immediately with no done pulse.
- With REGFILE_DUMP_CHECKSUM_EN: load 22, 7, 9 -> checksum 38 at done; a second start clears it to 0.
